// File: rtl/m_seg7_scan.sv
// m_seg7_scan: time-multiplexed driver for a common-anode seven-segment display.
// It captures a bundle of hex digits into a shadow register and scans them one
// digit at a time. Each digit slot starts with one dead cycle (all off) so that
// the previous digit does not ghost onto the next one.
//
// Build option: define SEG7_BLANK_EN to enable leading-zero blanking. In that
// build, digit i (i >= 1) stays dark for its whole slot while it and every
// higher digit are zero. Digit 0 is never blanked. Without the macro, every
// digit is displayed, so a zero digit shows as 0.
module m_seg7_scan #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic                ck,
  input  logic                res,
  input  logic                load,
  input  logic [4*DIGITS-1:0] d,
  input  logic [DIGITS-1:0]   dp_in,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [DIGITS-1:0]   an
);

  // The index register keeps at least one bit so that DIGITS = 1 still elaborates.
  localparam int unsigned PreW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DIGITS - 1);

  // Dark pattern shared by reset, dead time and blanked slots.
  localparam logic [6:0] SegOff = 7'h7F;

  // Convert one hex digit to active-low segments, bit order gfedcba.
  function automatic logic [6:0] seg7_decode(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Shadow register for the captured digits and decimal points.
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;

  // Scan state: position inside the current slot and the digit index.
  logic [PreW-1:0] pre_q, pre_d;
  logic [IdxW-1:0] idx_q, idx_d;

  // Registered outputs.
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [DIGITS-1:0] an_q, an_d;

  // Values selected by the current index.
  logic [3:0]        cur_digit;
  logic              cur_dp;
  logic              cur_blank;
  logic [DIGITS-1:0] an_sel;
  logic [DIGITS-1:0] blank;

  // Capture new digits on load; otherwise keep the held value.
  always_comb begin
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    if (load) begin
      shadow_d    = d;
      shadow_dp_d = dp_in;
    end
  end

  // The prescaler wraps after SCAN_DIV cycles and moves the scan to the next digit.
  always_comb begin
    pre_d = pre_q;
    idx_d = idx_q;
    if (pre_q == PreLast) begin
      pre_d = '0;
      if (idx_q == IdxLast) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else begin
      pre_d = pre_q + 1'b1;
    end
  end

  // Find leading zeros: a digit is blanked while it and every digit above it are zero.
  always_comb begin
    blank = '0;
`ifdef SEG7_BLANK_EN
    begin
      logic zero_run;
      zero_run = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
        zero_run = zero_run & (shadow_q[4*i +: 4] == 4'h0);
        blank[i] = zero_run;
      end
    end
`endif
  end

  // Select the digit, decimal point, blank flag and anode for the current index.
  always_comb begin
    cur_digit = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    an_sel    = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IdxW'(i)) begin
        cur_digit = shadow_q[4*i +: 4];
        cur_dp    = shadow_dp_q[i];
        cur_blank = blank[i];
        an_sel[i] = 1'b0;
      end
    end
  end

  // Slot position 0 is the dead cycle. A blanked digit stays dark for its whole slot.
  always_comb begin
    seg_d = SegOff;
    dp_d  = 1'b1;
    an_d  = '1;
    if ((pre_q != '0) && !cur_blank) begin
      seg_d = seg7_decode(cur_digit);
      dp_d  = ~cur_dp;
      an_d  = an_sel;
    end
  end

  // State and output registers; reset takes priority over load.
  always_ff @(posedge ck) begin
    if (res) begin
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      pre_q       <= '0;
      idx_q       <= '0;
      seg_q       <= SegOff;
      dp_q        <= 1'b1;
      an_q        <= '1;
    end else begin
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      pre_q       <= pre_d;
      idx_q       <= idx_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_m_seg7_scan.sv
// Self-checking bench for m_seg7_scan (DIGITS=4, SCAN_DIV=4). A driver pushes the
// expected output for every clock edge into a queue. A separate monitor pops each
// entry and compares it with the outputs on the following falling edge.
module tb_m_seg7_scan;

  localparam int unsigned DIG = 4;
  localparam int unsigned SD  = 4;
`ifdef SEG7_BLANK_EN
  localparam bit BlankOn = 1'b1;
`else
  localparam bit BlankOn = 1'b0;
`endif

  logic        ck = 1'b0;
  logic        res = 1'b1;
  logic        load = 1'b0;
  logic [15:0] d = '0;
  logic [3:0]  dp_in = '0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  m_seg7_scan #(.DIGITS(DIG), .SCAN_DIV(SD)) dut (
    .ck    (ck),
    .res   (res),
    .load  (load),
    .d     (d),
    .dp_in (dp_in),
    .seg   (seg),
    .dp    (dp),
    .an    (an)
  );

  always #5 ck = ~ck;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  string phase = "init";

  logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: edges since reset release, plus the shadow contents.
  int unsigned k_m = 0;
  logic [15:0] sh_m = '0;
  logic [3:0]  shdp_m = '0;

  function automatic bit is_blank(int unsigned i, logic [15:0] sh);
    return BlankOn && (i >= 1) && ((sh >> (4 * i)) == 16'h0);
  endfunction

  // Drive one edge's inputs, then record what the outputs must be after that edge.
  task automatic step(input logic r, input logic l, input logic [15:0] dv,
                      input logic [3:0] dpv);
    exp_t        e;
    int unsigned p;
    int unsigned ix;
    logic [3:0]  nib;
    @(negedge ck);
    res   = r;
    load  = l;
    d     = dv;
    dp_in = dpv;
    @(posedge ck);
    e.tag = phase;
    e.an  = 4'hF;
    e.seg = 7'h7F;
    e.dp  = 1'b1;
    if (r) begin
      k_m    = 0;
      sh_m   = '0;
      shdp_m = '0;
    end else begin
      p  = k_m % SD;
      ix = (k_m / SD) % DIG;
      if (p != 0 && !is_blank(ix, sh_m)) begin
        nib   = 4'((sh_m >> (4 * ix)) & 16'hF);
        e.an  = ~(4'b0001 << ix);
        e.seg = dec_tab[nib];
        e.dp  = ~shdp_m[ix];
      end
      if (l) begin
        sh_m   = dv;
        shdp_m = dpv;
      end
      k_m++;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 4'h0);
  endtask

  // Monitor: one comparison per recorded edge, sampled half a cycle later.
  always @(negedge ck) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (an !== e.an || seg !== e.seg || dp !== e.dp) begin
        n_bad++;
        $display("FAIL %s @%0t: got an=%h seg=%h dp=%b, required an=%h seg=%h dp=%b",
                 e.tag, $time, an, seg, dp, e.an, e.seg, e.dp);
      end
    end
  end

  initial begin
    logic [15:0] rv;
    bit          hit;

    // Reset, with one extra edge while reset is still held.
    phase = "reset";
    step(1'b1, 1'b0, 16'h0, 4'h0);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    phase = "first_lit";
    idle(2);
    phase = "scan_zero";
    idle(14);

    // Four distinct digits and one decimal point, watched over two frames.
    phase = "load_3A70";
    step(1'b0, 1'b1, 16'h3A70, 4'b0010);
    idle(32);

    // Decode sweep on digit 0; each value is watched for a full frame.
    for (int v = 0; v < 16; v++) begin
      $sformat(phase, "decode_%h", v[3:0]);
      step(1'b0, 1'b1, {12'h000, 4'(v)}, 4'h1);
      idle(16);
    end

    // Reset and load in the same cycle, mid-slot at index 2.
    phase = "seek_idx2";
    step(1'b0, 1'b1, 16'h3A70, 4'h0);
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if ((k_m / SD) % DIG == 2 && k_m % SD == 2) hit = 1'b1;
      else idle(1);
    end
    phase = "res_over_load";
    step(1'b1, 1'b1, 16'h3A70, 4'hF);
    phase = "restart";
    idle(20);

    // Leading zeros: blanked in the blanking build, shown as 0 otherwise.
    phase = "load_0050";
    step(1'b0, 1'b1, 16'h0050, 4'b1100);
    idle(32);

    // load held high: the display follows d one cycle behind.
    phase = "load_held";
    for (int i = 0; i < 40; i++) begin
      rv = 16'($urandom) >> (4 * $urandom_range(0, 4));
      step(1'b0, 1'b1, rv, 4'($urandom));
    end

    // Random traffic with occasional resets.
    phase = "random";
    for (int i = 0; i < 1500; i++) begin
      rv = 16'($urandom) >> (4 * $urandom_range(0, 4));
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 5) == 0), rv, 4'($urandom));
    end

    // Let the monitor drain the queue, then confirm nothing was left unchecked.
    @(negedge ck);
    @(negedge ck);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/m_seg7_scan.md
# m_seg7_scan

Time-multiplexed seven-segment display driver that sits directly downstream of the 4-bit counters. It captures a bundle of 4-bit hex digits from one or more counters into a shadow register and decodes each digit to segment patterns. It scans the digits one at a time onto a shared common-anode segment bus, with a dead-time cycle at every digit switch to suppress ghosting.

## Interface
Parameters:
- DIGITS, 4, number of multiplexed digits (1..8)
- SCAN_DIV, 1000, clock cycles each digit is held (≥ 2)

Ports:
- ck  in  1  system clock; all state changes on posedge ck
- res  in  1  reset, synchronous, active-high
- load  in  1  capture strobe for d and dp_in
- d  in  4*DIGITS  digit values; d[4i+3:4i] is digit i; digit 0 is rightmost
- dp_in  in  DIGITS  decimal-point request per digit (1 = lit)
- seg  out  7  segment cathodes, active-low; seg[0]=a … seg[6]=g
- dp  out  1  decimal-point cathode, active-low
- an  out  DIGITS  digit anode enables, active-low, at most one low

## Operation
- Shadow register:
  - On a posedge with load=1 and res=0, the shadow register takes d and dp_in.
  - Otherwise the shadow register holds its value.
  - Shadow reset value is all zeros.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - On wrap, the digit index advances by 1, and DIGITS-1 wraps to 0.
- Decode, active-low gfedcba:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex)
- Output register, updated every cycle from the current prescaler value, index and shadow:
  - Prescaler = 0 (dead time): an = all ones, seg = 7F, dp = 1.
  - Otherwise, for index i: an[i] = 0 and all other bits of an = 1; seg = decode(shadow digit i); dp = ~shadow_dp[i].
- Reset values:
  - Outputs: an = all ones, seg = 7F, dp = 1.
  - Internal state: prescaler = 0, index = 0, shadow = 0.
- Reset asserted mid-scan forces the reset values on the next edge. It overrides load in the same cycle.

## Timing
- All outputs are registered, with one cycle of latency from the internal state.
- After res deasserts (first edge with res=0 is edge E0):
  - Edge E0 leaves the prescaler at 1, and outputs show the dead-time pattern.
  - Edge E1 produces the first lit output: digit 0.
- Each digit slot lasts SCAN_DIV cycles: 1 dead cycle followed by SCAN_DIV-1 lit cycles.
- A full frame lasts DIGITS*SCAN_DIV cycles.
- Load visibility:
  - load sampled at edge N changes the shadow register at edge N.
  - The new value first appears on seg/an/dp at edge N+1, provided the current slot is lit at that edge.
  - The change takes effect mid-slot; no frame alignment is applied.
- load held high recaptures on every cycle. This is legal, and the display tracks d with one cycle of lag.
- DIGITS = 1: the index is constant 0 and the dead cycle still occurs every SCAN_DIV cycles.

## Configuration
- Macro SEG7_BLANK_EN: leading-zero blanking.
- Defined:
  - Digit i (i ≥ 1) is blanked when it and all higher digits are 0 in the shadow register.
  - A blanked slot drives the dead-time pattern for its whole duration: an all ones, seg = 7F, dp = 1.
  - Blanking ignores dp_in.
  - Digit 0 is never blanked.
  - Blanking is evaluated combinationally from the shadow register and is registered with the outputs.
- Undefined: every digit is always displayed, so 0 shows as 40.

## Test plan
Bench configuration for all scenarios: DIGITS=4, SCAN_DIV=4.
- Reset, then one idle edge followed by res=0:
  - At the edge after reset: an=F, seg=7F, dp=1.
  - After the first lit edge: an=E, seg=40.
- Load d=16'h3A70 with dp_in=4'b0010:
  - Slot 0: an=E, seg=40, dp=1.
  - Slot 1: an=D, seg=78, dp=0.
  - Slot 2: an=B, seg=08.
  - Slot 3: an=7, seg=30.
  - Each slot is preceded by exactly one an=F cycle; the frame is 16 cycles.
- Decode sweep: load each value 0..F into digit 0 and check seg against the decode table.
- Assert res with load=1 in the same cycle, mid-slot at index 2:
  - Next edge gives an=F, seg=7F, and the shadow stays 0.
  - The scan restarts at digit 0.
- With SEG7_BLANK_EN, load 16'h0050:
  - Digits 3 and 2 show an=F for their whole slots.
  - Digit 1 shows seg=12.
  - Digit 0 shows seg=40.
- Without SEG7_BLANK_EN, load 16'h0050: digits 3 and 2 show seg=40 with an=7 and an=B respectively.
